// File: rtl/cache_defs.sv
// Shared types and defaults for the main-memory arbiter between the dcache and the icache.
package cache_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_XFER = 2'd1,
    I_XFER = 2'd2,
    DRAIN  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_DC = 1'b0,
    OWNER_IC = 1'b1
  } arb_owner_e;

  localparam int MEM_ARB_MAX_CONSEC = 4;
  localparam int MEM_ARB_CONSEC_W   = 4;

  function automatic arb_owner_e other_owner(input arb_owner_e owner);
    return (owner == OWNER_DC) ? OWNER_IC : OWNER_DC;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection for mem_arbiter: eligibility, dcache priority with starvation limit,
// or a round-robin pointer when MEM_ARB_RR_EN is defined.
module mem_arb_grant
  import cache_defs::*;
#(
  parameter int MAX_CONSEC = MEM_ARB_MAX_CONSEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idle,
  input  logic       dc_req,
  input  logic       dc_ack,
  input  logic       dc_kill,
  input  logic       ic_req,
  input  logic       ic_ack,
`ifdef MEM_ARB_RR_EN
  input  logic       release_grant,
  input  arb_owner_e done_owner,
`endif
  output logic       grant_valid,
  output arb_owner_e grant_owner
);

  logic dc_elig;
  logic ic_elig;
  logic hold_off;

  // The ack-out cycle never grants, so a requester still holding req while it
  // sees its ack cannot be picked again and the other side waits one cycle.
  assign hold_off = dc_ack | ic_ack;
  assign dc_elig  = dc_req & ~dc_ack & ~dc_kill;
  assign ic_elig  = ic_req & ~ic_ack;

`ifdef MEM_ARB_RR_EN

  arb_owner_e rr_ptr;

  always_comb begin
    grant_valid = idle & ~hold_off & (dc_elig | ic_elig);
    grant_owner = OWNER_DC;
    if (dc_elig && ic_elig) begin
      grant_owner = rr_ptr;
    end else if (ic_elig) begin
      grant_owner = OWNER_IC;
    end
  end

  // Pointer moves away from whoever just finished, whether completed or drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= OWNER_DC;
    end else if (release_grant) begin
      rr_ptr <= other_owner(done_owner);
    end
  end

`else

  localparam logic [MEM_ARB_CONSEC_W-1:0] CONSEC_LIMIT = MEM_ARB_CONSEC_W'(MAX_CONSEC);

  logic [MEM_ARB_CONSEC_W-1:0] consec;

  always_comb begin
    grant_valid = idle & ~hold_off & (dc_elig | ic_elig);
    grant_owner = OWNER_DC;
    if (ic_elig && (!dc_elig || consec == CONSEC_LIMIT)) begin
      grant_owner = OWNER_IC;
    end
  end

  // Counts dcache grants that jumped a waiting icache request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      consec <= '0;
    end else if (!ic_req) begin
      consec <= '0;
    end else if (grant_valid) begin
      if (grant_owner == OWNER_IC) begin
        consec <= '0;
      end else if (consec != CONSEC_LIMIT) begin
        consec <= consec + 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter between the write-back dcache and the icache.
// Define MEM_ARB_RR_EN to replace fixed dcache priority with round-robin selection.
module mem_arbiter
  import cache_defs::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 4,
  parameter int MAX_CONSEC = MEM_ARB_MAX_CONSEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dc_req_i,
  input  logic              dc_w_en_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_w_data_i,
  input  logic [SEL_W-1:0]  dc_sel_byte_i,
  input  logic              dc_kill_i,
  output logic              dc_ack_o,
  output logic [DATA_W-1:0] dc_r_data_o,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ack_o,
  output logic [DATA_W-1:0] ic_r_data_o,
  output logic              mem_req_o,
  output logic              mem_w_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_w_data_o,
  output logic [SEL_W-1:0]  mem_sel_byte_o,
  output logic              mem_kill_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_r_data_i
);

  arb_state_e state;
  arb_state_e state_next;
  logic       grant_valid;
  arb_owner_e grant_owner;
  logic       idle;
  logic       load_payload;
  logic       dc_done;
  logic       ic_done;
  logic       req_next;
  logic       kill_next;

  assign idle = (state == IDLE);

`ifdef MEM_ARB_RR_EN
  logic       release_grant;
  arb_owner_e done_owner;

  assign release_grant = (state != IDLE) && mem_ack_i;
  assign done_owner    = (state == I_XFER) ? OWNER_IC : OWNER_DC;
`endif

  mem_arb_grant #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_grant (
    .clk           (clk),
    .rst           (rst),
    .idle          (idle),
    .dc_req        (dc_req_i),
    .dc_ack        (dc_ack_o),
    .dc_kill       (dc_kill_i),
    .ic_req        (ic_req_i),
    .ic_ack        (ic_ack_o),
`ifdef MEM_ARB_RR_EN
    .release_grant (release_grant),
    .done_owner    (done_owner),
`endif
    .grant_valid   (grant_valid),
    .grant_owner   (grant_owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A kill that lands with the memory ack just abandons the data; only an
  // earlier kill needs DRAIN to swallow the ack still owed by memory.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = (grant_owner == OWNER_DC) ? D_XFER : I_XFER;
        end
      end
      D_XFER: begin
        if (mem_ack_i) begin
          state_next = IDLE;
        end else if (dc_kill_i) begin
          state_next = DRAIN;
        end
      end
      I_XFER, DRAIN: begin
        if (mem_ack_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_payload = idle && grant_valid;
    dc_done      = (state == D_XFER) && mem_ack_i && !dc_kill_i;
    ic_done      = (state == I_XFER) && mem_ack_i;
    req_next     = (state_next != IDLE);
    kill_next    = (state_next == DRAIN);
  end

  // Payload is captured only on the grant edge and stays frozen until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_o      <= 1'b0;
      mem_kill_o     <= 1'b0;
      mem_w_en_o     <= 1'b0;
      mem_addr_o     <= '0;
      mem_w_data_o   <= '0;
      mem_sel_byte_o <= '0;
    end else begin
      mem_req_o  <= req_next;
      mem_kill_o <= kill_next;
      if (load_payload) begin
        if (grant_owner == OWNER_DC) begin
          mem_w_en_o     <= dc_w_en_i;
          mem_addr_o     <= dc_addr_i;
          mem_w_data_o   <= dc_w_data_i;
          mem_sel_byte_o <= dc_sel_byte_i;
        end else begin
          mem_w_en_o     <= 1'b0;
          mem_addr_o     <= ic_addr_i;
          mem_w_data_o   <= '0;
          mem_sel_byte_o <= '1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_ack_o    <= 1'b0;
      ic_ack_o    <= 1'b0;
      dc_r_data_o <= '0;
      ic_r_data_o <= '0;
    end else begin
      dc_ack_o <= dc_done;
      ic_ack_o <= ic_done;
      if (dc_done) begin
        dc_r_data_o <= mem_r_data_i;
      end
      if (ic_done) begin
        ic_r_data_o <= mem_r_data_i;
      end
    end
  end

endmodule
